// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 32 x 64-bit architectural register file.
package regfile_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ZERO_REG   = 31;
  localparam int unsigned DATA_WIDTH = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/regfile_64x32_mux_32to1.sv
// 1-bit 32:1 multiplexer built as a five-level tree of 2:1 muxes.
module mux_32to1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  logic [15:0] l1;
  logic [7:0]  l2;
  logic [3:0]  l3;
  logic [1:0]  l4;

  always_comb begin
    l1 = '0;
    l2 = '0;
    l3 = '0;
    l4 = '0;
    for (int unsigned i = 0; i < 16; i++) l1[i] = sel[0] ? d[2*i+1]  : d[2*i];
    for (int unsigned i = 0; i < 8;  i++) l2[i] = sel[1] ? l1[2*i+1] : l1[2*i];
    for (int unsigned i = 0; i < 4;  i++) l3[i] = sel[2] ? l2[2*i+1] : l2[2*i];
    for (int unsigned i = 0; i < 2;  i++) l4[i] = sel[3] ? l3[2*i+1] : l3[2*i];
    y = sel[4] ? l4[1] : l4[0];
  end
endmodule

// File: rtl/regfile_64x32.sv
// 32 x 64-bit register file, two combinational read ports, register 31 reads zero.
// Optional write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_64x32
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [REG_ADDR_W-1:0] read_reg1,
  input  logic [REG_ADDR_W-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);
  reg_data_t             regs [ZERO_REG];
  logic [ZERO_REG-1:0]   write_sel;
  logic [NUM_REGS-1:0]   col [DATA_WIDTH];
  reg_data_t             stored1;
  reg_data_t             stored2;

  always_comb begin
    write_sel = '0;
    for (int unsigned i = 0; i < ZERO_REG; i++)
      write_sel[i] = write_enable && (write_reg == reg_addr_t'(i));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ZERO_REG; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ZERO_REG; i++)
        if (write_sel[i]) regs[i] <= write_data;
    end
  end

  // Transpose storage into per-bit columns; the zero register has no storage and feeds 0.
  always_comb begin
    for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
      col[b] = '0;
      for (int unsigned r = 0; r < ZERO_REG; r++) col[b][r] = regs[r][b];
      col[b][ZERO_REG] = 1'b0;
    end
  end

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
    mux_32to1 u_mux1 (.d(col[b]), .sel(read_reg1), .y(stored1[b]));
    mux_32to1 u_mux2 (.d(col[b]), .sel(read_reg2), .y(stored2[b]));
  end

`ifdef REGFILE_BYPASS_EN
  // write_reg != ZERO_REG keeps the zero register ahead of the bypass.
  always_comb begin
    read_data1 = stored1;
    read_data2 = stored2;
    if (write_enable && (write_reg != reg_addr_t'(ZERO_REG))) begin
      if (read_reg1 == write_reg) read_data1 = write_data;
      if (read_reg2 == write_reg) read_data2 = write_data;
    end
  end
`else
  always_comb begin
    read_data1 = stored1;
    read_data2 = stored2;
  end
`endif
endmodule

// File: tb/tb_regfile_64x32.sv
// Scoreboard bench for regfile_64x32; honours REGFILE_BYPASS_EN for the collision case.
module tb_regfile_64x32;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      clk_run = 1'b0;
  logic      reset = 1'b1;
  logic      write_enable = 1'b0;
  reg_addr_t write_reg = '0;
  reg_data_t write_data = '0;
  reg_addr_t read_reg1 = '0;
  reg_addr_t read_reg2 = '0;
  reg_data_t read_data1;
  reg_data_t read_data2;

  typedef struct {
    string     name;
    reg_data_t e1;
    reg_data_t e2;
  } exp_t;

  exp_t      sb [$];
  event      mon_ev;
  int        checks = 0;
  int        fails = 0;
  reg_data_t model [ZERO_REG];

  regfile_64x32 dut (
    .clk(clk), .reset(reset), .write_enable(write_enable), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  initial forever begin
    #10;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  // Monitor: pops expected read values and compares against the DUT outputs.
  initial forever begin
    @(mon_ev);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (read_data1 !== e.e1 || read_data2 !== e.e2) begin
        fails++;
        $display("FAIL %s: read_data1=%h expected %h, read_data2=%h expected %h",
                 e.name, read_data1, e.e1, read_data2, e.e2);
      end
    end
  end

  function automatic reg_data_t exp_of(input int unsigned i);
    return (i >= ZERO_REG) ? '0 : model[i];
  endfunction

  task automatic chk(input string name, input int unsigned a1, input int unsigned a2,
                     input reg_data_t e1, input reg_data_t e2);
    exp_t e;
    read_reg1 = reg_addr_t'(a1);
    read_reg2 = reg_addr_t'(a2);
    #5;
    e.name = name;
    e.e1 = e1;
    e.e2 = e2;
    sb.push_back(e);
    ->mon_ev;
    #1;
  endtask

  task automatic do_write(input int unsigned a, input reg_data_t v);
    @(negedge clk);
    write_enable = 1'b1;
    write_reg = reg_addr_t'(a);
    write_data = v;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    if (a < ZERO_REG) model[a] = v;
  endtask

  initial begin
    for (int i = 0; i < 31; i++) model[i] = '0;

    // Reset held, clock stopped: every index reads 0 on both ports.
    #5;
    for (int i = 0; i < 32; i++) chk("reset_all", i, 31 - i, '0, '0);

    reset = 1'b0;
    #3;
    clk_run = 1'b1;

    do_write(5, 64'hDEAD_BEEF_0000_0001);
    chk("write_r5", 5, 5, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
    #4;
    reset = 1'b1;
    for (int i = 0; i < 31; i++) model[i] = '0;
    chk("async_reset_r5", 5, 31, '0, '0);

    // Write attempted across an edge while reset is held: reset wins.
    write_enable = 1'b1;
    write_reg = 5'd9;
    write_data = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1;
    chk("reset_beats_write", 9, 5, '0, '0);
    write_enable = 1'b0;
    #2;
    reset = 1'b0;

    for (int i = 0; i < 31; i++) do_write(i, 64'h1111_1111_1111_1111 * 64'(i + 1));
    for (int i = 0; i < 31; i++) chk("sweep", i, i ^ 1, exp_of(i), exp_of(i ^ 1));
    chk("sweep_r0", 0, 1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222);
    chk("sweep_r15", 15, 14, 64'h1111_1111_1111_1110, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sweep_r31", 31, 31, '0, '0);

    do_write(31, '1);
    chk("zero_reg_write", 31, 31, '0, '0);
    for (int i = 0; i < 31; i++) chk("zero_reg_no_side_effect", i, 31, exp_of(i), '0);

    @(negedge clk);
    write_enable = 1'b0;
    write_reg = 5'd7;
    write_data = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("disabled_write", 7, 7, 64'h8888_8888_8888_8888, 64'h8888_8888_8888_8888);

    @(negedge clk);
    write_enable = 1'b1;
    write_reg = 5'd12;
    write_data = 64'hAAAA_5555_AAAA_5555;
`ifdef REGFILE_BYPASS_EN
    chk("collide_pre", 12, 12, 64'hAAAA_5555_AAAA_5555, 64'hAAAA_5555_AAAA_5555);
`else
    chk("collide_pre", 12, 12, 64'hDDDD_DDDD_DDDD_DDDD, 64'hDDDD_DDDD_DDDD_DDDD);
`endif
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    model[12] = 64'hAAAA_5555_AAAA_5555;
    chk("collide_post", 12, 12, 64'hAAAA_5555_AAAA_5555, 64'hAAAA_5555_AAAA_5555);

    @(negedge clk);
    write_enable = 1'b1;
    write_reg = 5'd3;
    write_data = 64'd1;
    @(negedge clk);
    write_data = 64'd2;
    @(negedge clk);
    write_reg = 5'd4;
    write_data = 64'd3;
    @(negedge clk);
    write_enable = 1'b0;
    model[3] = 64'd2;
    model[4] = 64'd3;
    chk("back_to_back", 3, 4, 64'd2, 64'd3);
    for (int i = 0; i < 31; i++) chk("back_to_back_others", i, 30 - i, exp_of(i), exp_of(30 - i));

    #20;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
